// File: rtl/sampler_pkg.sv
// sampler_pkg: shared types and constants for the constraint sampler.
//   state_t      - sampler FSM state encoding
//   DEFAULT_TAPS - default Galois LFSR feedback mask (64-bit)
package sampler_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STEP = 3'd1,
    EVAL = 3'd2,
    EMIT = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [63:0] DEFAULT_TAPS = 64'hD800_0000_0000_0001;

endpackage

// File: rtl/constraint_sampler_if.sv
// constraint_sampler_if: accepted-sample stream (valid/ready).
//   out_valid - sample present
//   out_data  - sample value, held while out_valid && !out_ready
//   out_ready - consumer accepts on out_valid && out_ready
//   master: sampler side, slave: consumer side
interface constraint_sampler_if #(
  parameter int CAND_W = 64
);
  logic              out_valid;
  logic [CAND_W-1:0] out_data;
  logic              out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/sampler_lfsr.sv
// sampler_lfsr: Galois LFSR candidate generator.
//   clk, rst - clock, synchronous active-high reset (state -> all-ones)
//   load     - load seed (a zero seed is replaced by all-ones, the
//              all-zero state being a lock-up state)
//   step     - advance one Galois step: shift right, XOR TAPS if old LSB was 1
//   seed     - load value
//   state    - current LFSR state
module sampler_lfsr
  import sampler_pkg::*;
#(
  parameter int                CAND_W = 64,
  parameter logic [CAND_W-1:0] TAPS   = CAND_W'(DEFAULT_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [CAND_W-1:0] seed,
  output logic [CAND_W-1:0] state
);

  logic [CAND_W-1:0] nxt;

  always_comb nxt = (state >> 1) ^ (state[0] ? TAPS : '0);

  always_ff @(posedge clk) begin
    if (rst)       state <= '1;
    else if (load) state <= (seed == '0) ? '1 : seed;
    else if (step) state <= nxt;
  end

endmodule

// File: rtl/constraint_sampler.sv
// constraint_sampler: rejection sampler driving an external combinational
// constraint checker with successive LFSR states, emitting those it accepts.
//   clk, rst            - clock, synchronous active-high reset
//   start, seed,
//   num_samples         - run request (only honoured in IDLE)
//   cand / sat          - candidate to the checker / checker verdict
//   smp (master)        - accepted-sample stream out_valid/out_data/out_ready
//   busy, done, fail    - not-idle level, run complete pulse, try-limit abort pulse
//   total_tries         - (SAMPLER_STATS_EN only) saturating count of EVAL cycles
// Build option: define SAMPLER_STATS_EN to add the total_tries counter/port.
module constraint_sampler
  import sampler_pkg::*;
#(
  parameter int                CAND_W    = 64,
  parameter logic [CAND_W-1:0] TAPS      = CAND_W'(DEFAULT_TAPS),
  parameter int                CNT_W     = 16,
  parameter int                MAX_TRIES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CAND_W-1:0]    seed,
  input  logic [CNT_W-1:0]     num_samples,
  output logic [CAND_W-1:0]    cand,
  input  logic                 sat,
  constraint_sampler_if.master smp,
  output logic                 busy,
  output logic                 done,
`ifdef SAMPLER_STATS_EN
  output logic                 fail,
  output logic [31:0]          total_tries
`else
  output logic                 fail
`endif
);

  localparam logic [CNT_W-1:0] TRY_LAST = CNT_W'(MAX_TRIES - 1);

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  tries;
  logic [CAND_W-1:0] lfsr_state;
  logic              cand_vld;
  logic              accept;
  logic              try_out;

  assign accept  = (state == IDLE) && start;
  assign try_out = !sat && (tries == TRY_LAST);

  sampler_lfsr #(.CAND_W(CAND_W), .TAPS(TAPS)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (state == STEP),
    .seed  (seed),
    .state (lfsr_state)
  );

  // The LFSR register advances on the STEP edge, so its output is already the
  // new candidate for the whole EVAL cycle. cand_vld only forces cand to zero
  // out of reset, before the first step (the LFSR itself resets to all-ones).
  assign cand = lfsr_state & {CAND_W{cand_vld}};
  assign smp.out_data = cand;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: if (start) nxt_state = (num_samples == '0) ? FIN : STEP;
      STEP: nxt_state = EVAL;
      EVAL: begin
        if (sat)          nxt_state = EMIT;
        else if (try_out) nxt_state = IDLE;
        else              nxt_state = STEP;
      end
      EMIT: if (smp.out_ready) nxt_state = (remaining == CNT_W'(1)) ? FIN : STEP;
      FIN:  nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy          = (state != IDLE);
    smp.out_valid = (state == EMIT);
    done          = (state == FIN);
    fail          = (state == EVAL) && try_out;
  end

  // counters and candidate-valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      tries     <= '0;
      cand_vld  <= 1'b0;
    end else begin
      if (accept) begin
        remaining <= num_samples;
        tries     <= '0;
      end
      if (state == STEP) cand_vld <= 1'b1;
      if (state == EVAL) tries <= (sat || try_out) ? '0 : tries + CNT_W'(1);
      if (state == EMIT && smp.out_ready) remaining <= remaining - CNT_W'(1);
    end
  end

`ifdef SAMPLER_STATS_EN
  // Lifetime count of checker evaluations; survives start, saturates.
  always_ff @(posedge clk) begin
    if (rst)                                    total_tries <= '0;
    else if (state == EVAL && total_tries != '1) total_tries <= total_tries + 32'd1;
  end
`endif

endmodule
